// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a small show-ahead byte FIFO with sticky line-error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic       overrun,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t             state, state_nx;
   logic               rx_s1, rxs;
   logic [CNT_W-1:0]   cyc_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift_reg;
   logic               cnt_clr, bit_clr, shift_en, push_req, frame_evt, parity_evt;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_nx;
   logic [FCNT_W-1:0]  count;
   logic               do_pop, do_push, overrun_evt;

   // Receiver control: next state and per-cycle strobes
   always_comb begin
      state_nx   = state;
      cnt_clr    = 1'b0;
      bit_clr    = 1'b0;
      shift_en   = 1'b0;
      push_req   = 1'b0;
      frame_evt  = 1'b0;
      parity_evt = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_nx = START;
               cnt_clr  = 1'b1;
               bit_clr  = 1'b1;
            end
         end
         START: begin
            if (cyc_cnt == HALF) begin
               cnt_clr  = 1'b1;
               state_nx = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cyc_cnt == LAST) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nx = PARITY;
`else
                  state_nx = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cyc_cnt == LAST) begin
               cnt_clr    = 1'b1;
               parity_evt = ^{shift_reg, rxs};
               state_nx   = STOP;
            end
         end
`endif
         STOP: begin
            if (cyc_cnt == LAST) begin
               cnt_clr = 1'b1;
               if (rxs) begin
                  push_req = 1'b1;
                  state_nx = IDLE;
               end else begin
                  frame_evt = 1'b1;
                  state_nx  = BREAK;
               end
            end
         end
         BREAK: begin
            if (rxs) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign empty       = (count == '0);
   assign full        = (count == FCNT_W'(FIFO_DEPTH));
   assign do_pop      = rd_en & ~empty;
   assign do_push     = push_req & (~full | do_pop);
   assign overrun_evt = push_req & full & ~do_pop;
   assign rd_ptr_nx   = rd_ptr + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rx_s1     <= 1'b1;
         rxs       <= 1'b1;
         cyc_cnt   <= '0;
         bit_cnt   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_data   <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state   <= state_nx;
         rx_s1   <= rx_in;
         rxs     <= rx_s1;
         cyc_cnt <= cnt_clr ? '0 : cyc_cnt + CNT_W'(1);
         if (bit_clr)       bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr_nx;
         case ({do_push, do_pop})
            2'b10:   count <= count + FCNT_W'(1);
            2'b01:   count <= count - FCNT_W'(1);
            default: count <= count;
         endcase

         // Show-ahead head register: an incoming byte lands here when it becomes the head
         if (do_pop) begin
            if (count > FCNT_W'(1)) rd_data <= mem[rd_ptr_nx];
            else if (do_push)       rd_data <= shift_reg;
         end else if (do_push && empty) begin
            rd_data <= shift_reg;
         end

         overrun   <= (overrun & ~clr_err) | overrun_evt;
         frame_err <= (frame_err & ~clr_err) | frame_evt;
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en) shift_reg <= {rxs, shift_reg[7:1]};
      if (do_push)  mem[wr_ptr] <= shift_reg;
   end

`ifdef UART_RX_PARITY_EN
   logic parity_err_q;
   always_ff @(posedge clk) begin
      if (rst) parity_err_q <= 1'b0;
      else     parity_err_q <= (parity_err_q & ~clr_err) | parity_evt;
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
